// File: rtl/somador_sequencial.sv
// =============================================================================
// somador_sequencial
// -----------------------------------------------------------------------------
// Digit-serial two's-complement adder/subtractor. A WIDTH-bit operation is
// carried out DIGIT bits per clock, least significant slice first, so the
// combinational carry chain is only DIGIT bits long. The carry chain across
// the whole operation is identical to a WIDTH-bit ripple adder with carry-in
// C0.
//
// Optional feature (compile-time macro SOMADOR_ACUM_EN):
//   When defined, an extra input ACUM selects the previous result
//   SOMA[WIDTH-1:0] as operand A, turning the block into an accumulator
//   (SOMA <- SOMA +/- B). When undefined, A always comes from the A port.
//
// Parameters:
//   WIDTH       operand width in bits, must be a multiple of DIGIT
//   DIGIT       bits processed per clock, 1 <= DIGIT <= WIDTH
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous active-high reset
//   START       request a new operation (only looked at while idle)
//   A, B        operands, sampled on the accepting edge
//   C0          0 = A+B, 1 = A-B (B inverted, carry-in 1)
//   ACUM        (SOMADOR_ACUM_EN only) 1 = use previous SOMA as operand A
//   BUSY        high while an operation is in progress
//   DONE        one-cycle pulse, SOMA/OVF just updated
//   SOMA        {carry-out, result}; for subtraction carry-out 1 = no borrow
//   OVF         signed overflow of the last result
//   dbg_state_o current FSM state (0 = IDLE, 1 = CALC)
//
// Handshake: START is sampled on every rising edge while the block is idle
// (BUSY=0); the edge that sees START=1 accepts the operation and also samples
// A, B, C0 (and ACUM). START while BUSY=1 is ignored and never queued.
// Exactly N = WIDTH/DIGIT edges later the result is written and DONE is high
// for the following cycle only; START held high during that DONE cycle is
// accepted on the next edge.
// =============================================================================
module somador_sequencial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
`ifdef SOMADOR_ACUM_EN
   input  logic             ACUM,
`endif
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH:0]   SOMA,
   output logic             OVF,
   output logic             dbg_state_o
);

   // Number of slices per operation and counter width (at least one bit so
   // the DIGIT == WIDTH case still has a legal vector).
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_CALC  = 1'b1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;      // operand A, shifted right per slice
   logic [WIDTH-1:0] b_q,     b_d;      // operand B (already inverted for sub)
   logic [WIDTH-1:0] res_q,   res_d;    // result, filled from the top down
   logic             carry_q, carry_d;  // running carry between slices
   logic [WIDTH:0]   soma_q,  soma_d;
   logic             ovf_q,   ovf_d;
   logic             done_q,  done_d;

   // -------------------------------------------------------------------------
   // Operand A source
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] op_a;

`ifdef SOMADOR_ACUM_EN
   assign op_a = ACUM ? soma_q[WIDTH-1:0] : A;
`else
   assign op_a = A;
`endif

   // -------------------------------------------------------------------------
   // One DIGIT-bit ripple slice on the low bits of the operand registers.
   // slice_cmsb is the carry into the top bit of the slice; on the last slice
   // that is the carry into the MSB of the whole word, which together with
   // the carry-out gives signed overflow.
   // -------------------------------------------------------------------------
   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_cmsb;

   always_comb begin
      logic c;
      c          = carry_q;
      slice_sum  = '0;
      slice_cmsb = carry_q;
      for (int i = 0; i < DIGIT; i++) begin
         slice_cmsb   = c;
         slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
         c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
      end
      slice_cout = c;
   end

   // The new slice enters the result register at the top; after N slices the
   // first one has travelled down to bit 0.
   logic [WIDTH-1:0] slice_ext;
   assign slice_ext = WIDTH'(slice_sum);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      soma_d  = soma_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               a_d     = op_a;
               b_d     = B ^ {WIDTH{C0}};
               carry_d = C0;
               cnt_d   = '0;
               res_d   = '0;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
            carry_d = slice_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               // Final slice: publish the full word on this same edge.
               soma_d  = {slice_cout, res_d};
               ovf_d   = slice_cmsb ^ slice_cout;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers. Reset aborts any operation in flight without a DONE pulse.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         soma_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         soma_q  <= soma_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign BUSY        = (state_q == ST_CALC);
   assign DONE        = done_q;
   assign SOMA        = soma_q;
   assign OVF         = ovf_q;
   assign dbg_state_o = state_q[0];

endmodule

// File: tb/tb_somador_sequencial.sv
// =============================================================================
// tb_somador_sequencial
// -----------------------------------------------------------------------------
// Directed bench for somador_sequencial. Two instances share the same inputs:
// u_dut (WIDTH=16, DIGIT=4, four slices) is the main subject; u_dut1
// (WIDTH=16, DIGIT=16, one slice) confirms single-edge latency. Expected
// values are hand-computed constants. With SOMADOR_ACUM_EN defined the
// accumulator path is exercised as well.
// =============================================================================
module tb_somador_sequencial;

   localparam int WIDTH = 16;
   localparam int N     = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C0;
`ifdef SOMADOR_ACUM_EN
   logic             ACUM;
`endif

   logic             BUSY,  BUSY1;
   logic             DONE,  DONE1;
   logic [WIDTH:0]   SOMA,  SOMA1;
   logic             OVF,   OVF1;
   logic             dbg_state, dbg_state1;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt;

   // ---------------------------------------------------------------- clock
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------- DUTs
   somador_sequencial #(.WIDTH(WIDTH), .DIGIT(4)) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .A           (A),
      .B           (B),
      .C0          (C0),
`ifdef SOMADOR_ACUM_EN
      .ACUM        (ACUM),
`endif
      .BUSY        (BUSY),
      .DONE        (DONE),
      .SOMA        (SOMA),
      .OVF         (OVF),
      .dbg_state_o (dbg_state)
   );

   somador_sequencial #(.WIDTH(WIDTH), .DIGIT(16)) u_dut1 (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .A           (A),
      .B           (B),
      .C0          (C0),
`ifdef SOMADOR_ACUM_EN
      .ACUM        (ACUM),
`endif
      .BUSY        (BUSY1),
      .DONE        (DONE1),
      .SOMA        (SOMA1),
      .OVF         (OVF1),
      .dbg_state_o (dbg_state1)
   );

   // ---------------------------------------------------------------- checker
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge (input drive point).
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One full operation on both instances with cycle-by-cycle handshake checks.
   // Called 1 unit after a rising edge with both instances idle.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic acum,
                        input logic [16:0] exp_soma, input logic exp_ovf);
      START = 1'b1;
      A     = a;
      B     = b;
      C0    = c0;
`ifdef SOMADOR_ACUM_EN
      ACUM  = acum;
`endif
      tick();                       // accepting edge k
      START = 1'b0;
`ifdef SOMADOR_ACUM_EN
      ACUM  = 1'b0;
`endif
      for (int i = 1; i <= N; i++) begin
         @(negedge CLK);
         chk({tag, "_busy"}, 32'(BUSY), 32'h1);
         chk({tag, "_nodone"}, 32'(DONE), 32'h0);
         if (i == 1) begin
            chk({tag, "_n1_busy"}, 32'(BUSY1), 32'h1);
         end
         if (i == 2) begin
            chk({tag, "_n1_done"}, 32'(DONE1), 32'h1);
            chk({tag, "_n1_soma"}, 32'(SOMA1), 32'(exp_soma));
            chk({tag, "_n1_ovf"}, 32'(OVF1), 32'(exp_ovf));
         end
         tick();
      end
      @(negedge CLK);               // cycle after edge k+N
      chk({tag, "_done"}, 32'(DONE), 32'h1);
      chk({tag, "_idle"}, 32'(BUSY), 32'h0);
      chk({tag, "_soma"}, 32'(SOMA), 32'(exp_soma));
      chk({tag, "_ovf"}, 32'(OVF), 32'(exp_ovf));
      tick();
      @(negedge CLK);
      chk({tag, "_done_pulse"}, 32'(DONE), 32'h0);
      chk({tag, "_soma_hold"}, 32'(SOMA), 32'(exp_soma));
      tick();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      RST   = 1'b1;
      START = 1'b0;
      A     = '0;
      B     = '0;
      C0    = 1'b0;
`ifdef SOMADOR_ACUM_EN
      ACUM  = 1'b0;
`endif

      // Reset state
      tick();
      tick();
      @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_soma", 32'(SOMA), 32'h0);
      chk("rst_ovf", 32'(OVF), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      tick();
      RST = 1'b0;
      tick();

      // Arithmetic
      do_op("add", 16'h1234, 16'h0FF1, 1'b0, 1'b0, 17'h02225, 1'b0);
`ifdef SOMADOR_ACUM_EN
      // 0x2225 - 1 = 0x2224, no borrow
      do_op("acum_sub", 16'hDEAD, 16'h0001, 1'b1, 1'b1, 17'h12224, 1'b0);
      // 0x2224 + 0x0100, A port ignored
      do_op("acum_add", 16'hFFFF, 16'h0100, 1'b0, 1'b1, 17'h02324, 1'b0);
`endif
      do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 17'h0FFFE, 1'b0);
      do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
      do_op("carry_out", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
      do_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 17'h17FFF, 1'b1);

      // Reset on the 3rd CALC edge: abort, no DONE, outputs cleared
      START = 1'b1; A = 16'h1234; B = 16'h0FF1; C0 = 1'b0;
      tick();                       // accept edge k
      START = 1'b0;
      tick();                       // k+1
      tick();                       // k+2
      RST = 1'b1;
      tick();                       // k+3 resets
      RST = 1'b0;
      @(negedge CLK);
      chk("abort_busy", 32'(BUSY), 32'h0);
      chk("abort_done", 32'(DONE), 32'h0);
      chk("abort_soma", 32'(SOMA), 32'h0);
      chk("abort_ovf", 32'(OVF), 32'h0);
      chk("abort_state", 32'(dbg_state), 32'h0);
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge CLK);
         if (DONE) done_cnt++;
      end
      chk("abort_no_done", 32'(done_cnt), 32'h0);
      tick();

      // START pulsed 2 cycles into an operation is ignored
      START = 1'b1; A = 16'h1111; B = 16'h2222; C0 = 1'b0;
      tick();                       // accept edge k
      START = 1'b0;
      tick();                       // k+1
      tick();                       // k+2
      START = 1'b1; A = 16'hFFFF; B = 16'hFFFF; C0 = 1'b1;
      tick();                       // k+3, must be ignored
      START = 1'b0; A = '0; B = '0; C0 = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (DONE) done_cnt++;
         tick();
      end
      chk("ign_one_done", 32'(done_cnt), 32'h1);
      chk("ign_soma", 32'(SOMA), 32'h03333);
      chk("ign_idle", 32'(BUSY), 32'h0);

      // Back-to-back: START held through the DONE cycle
      START = 1'b1; A = 16'h0001; B = 16'h0001; C0 = 1'b0;
      tick();                       // accept edge k
      for (int i = 0; i < N; i++) tick();
      @(negedge CLK);               // DONE cycle of the first operation
      chk("b2b_done1", 32'(DONE), 32'h1);
      chk("b2b_soma1", 32'(SOMA), 32'h00002);
      A = 16'h0010; B = 16'h0020;
      tick();                       // edge k+N+1 accepts the second
      START = 1'b0;
      @(negedge CLK);
      chk("b2b_busy2", 32'(BUSY), 32'h1);
      chk("b2b_nodone", 32'(DONE), 32'h0);
      for (int i = 0; i < N; i++) tick();
      @(negedge CLK);
      chk("b2b_done2", 32'(DONE), 32'h1);
      chk("b2b_soma2", 32'(SOMA), 32'h00030);
      tick();
      tick();

      // RST and START on the same edge: not accepted
      RST = 1'b1; START = 1'b1; A = 16'h4321; B = 16'h1111;
      tick();
      RST = 1'b0; START = 1'b0;
      @(negedge CLK);
      chk("rst_start_busy", 32'(BUSY), 32'h0);
      chk("rst_start_soma", 32'(SOMA), 32'h0);
      tick();
      @(negedge CLK);
      chk("rst_start_busy2", 32'(BUSY), 32'h0);
      tick();

      // Recovery and a few more patterns
      do_op("add_mixed", 16'hABCD, 16'h1234, 1'b0, 1'b0, 17'h0BE01, 1'b0);
      do_op("sub_equal", 16'h1234, 16'h1234, 1'b1, 1'b0, 17'h10000, 1'b0);
      do_op("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 17'h17FFF, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time bound reached");
   end

endmodule
